// File: rtl/oldland_defines.sv
// Shared encodings for the oldland memory stage and its lane helper.
package oldland_defines;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/oldland_mem_lanes.sv
// Little-endian lane logic: byte enables, store replication, load extraction
// and alignment check. Purely combinational so a cache can reuse it.
module oldland_mem_lanes
    import oldland_defines::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_val,
    input  logic [31:0] rd_data,
    output logic [3:0]  bytesel,
    output logic [31:0] wr_rep,
    output logic [31:0] rd_ext,
    output logic        misaligned
);

    always_comb begin
        bytesel    = 4'b1111;
        wr_rep     = wr_val;
        rd_ext     = rd_data;
        misaligned = (addr_lo != 2'b00);
        case (width)
            MEM_BYTE: begin
                bytesel    = 4'b0001 << addr_lo;
                wr_rep     = {4{wr_val[7:0]}};
                rd_ext     = {24'h0, rd_data[{addr_lo, 3'b000} +: 8]};
                misaligned = 1'b0;
            end
            MEM_HALF: begin
                bytesel    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_rep     = {2{wr_val[15:0]}};
                rd_ext     = {16'h0, (addr_lo[1] ? rd_data[31:16] : rd_data[15:0])};
                misaligned = addr_lo[0];
            end
            default: ;  // word and the reserved encoding behave identically
        endcase
    end

endmodule

// File: rtl/oldland_memory.sv
// Oldland memory stage: runs load/store bus transactions, forwards ALU results
// to writeback and pulses stall_clear once per stalling instruction.
//
// state       | meaning
// ST_IDLE     | accepting a new instruction every cycle
// ST_ACCESS   | bus request held, waiting for d_ack or timeout
// ST_COMPLETE | one-cycle writeback slot for the memory result
module oldland_memory
    import oldland_defines::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic        branch,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_val,
    input  logic [1:0]  mem_width,
    input  logic [31:0] alu_result,
    input  logic [2:0]  rd_sel_in,
    input  logic        update_rd_in,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_val,
    output logic        d_wr_en,
    output logic        d_access,
    input  logic        d_ack,
    input  logic [31:0] d_data,
    output logic [31:0] wr_val,
    output logic [2:0]  rd_sel,
    output logic        update_rd,
    output logic        stall_clear,
    output logic        busy,
    output logic        bus_error
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);

    mem_state_t     state, state_next;
    logic [CW-1:0]  count;
    logic [31:0]    addr_q;
    logic [1:0]     width_q;
    logic [3:0]     bytesel_q;
    logic [31:0]    wr_rep_q;
    logic           is_store_q;
    logic [2:0]     rd_q;

    logic           start_mem;
    logic           timeout_hit;
    logic [1:0]     lane_width;
    logic [1:0]     lane_addr;
    logic [3:0]     lane_bytesel;
    logic [31:0]    lane_wr_rep;
    logic [31:0]    lane_rd_ext;
    logic           lane_misaligned;

    assign start_mem   = load | store;
    assign timeout_hit = (count == CW'(BUS_TIMEOUT - 1));

    // Inputs are decoded while idle; the latched request is used for extraction.
    assign lane_width = (state == ST_IDLE) ? mem_width     : width_q;
    assign lane_addr  = (state == ST_IDLE) ? mem_addr[1:0] : addr_q[1:0];

    oldland_mem_lanes u_lanes (
        .width      (lane_width),
        .addr_lo    (lane_addr),
        .wr_val     (mem_wr_val),
        .rd_data    (d_data),
        .bytesel    (lane_bytesel),
        .wr_rep     (lane_wr_rep),
        .rd_ext     (lane_rd_ext),
        .misaligned (lane_misaligned)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_mem)
                    state_next = lane_misaligned ? ST_COMPLETE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (d_ack || timeout_hit)
                    state_next = ST_COMPLETE;
            end
            ST_COMPLETE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE) || start_mem;
    assign d_access  = (state == ST_ACCESS);
    assign d_addr    = d_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign d_bytesel = d_access ? bytesel_q : 4'h0;
    assign d_wr_val  = d_access ? wr_rep_q : 32'h0;
    assign d_wr_en   = d_access && is_store_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            addr_q      <= '0;
            width_q     <= '0;
            bytesel_q   <= '0;
            wr_rep_q    <= '0;
            is_store_q  <= 1'b0;
            rd_q        <= '0;
            wr_val      <= '0;
            rd_sel      <= '0;
            update_rd   <= 1'b0;
            stall_clear <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            state       <= state_next;
            wr_val      <= '0;
            update_rd   <= 1'b0;
            stall_clear <= 1'b0;
            bus_error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_mem) begin
                        addr_q     <= mem_addr;
                        width_q    <= mem_width;
                        bytesel_q  <= lane_bytesel;
                        wr_rep_q   <= lane_wr_rep;
                        is_store_q <= store;
                        rd_q       <= rd_sel_in;
                        count      <= '0;
                        if (lane_misaligned) begin
                            rd_sel      <= rd_sel_in;
                            stall_clear <= 1'b1;
                            bus_error   <= 1'b1;
                        end
                    end else begin
                        wr_val      <= alu_result;
                        rd_sel      <= rd_sel_in;
                        update_rd   <= update_rd_in;
                        stall_clear <= branch;
                    end
                end
                ST_ACCESS: begin
                    if (d_ack) begin
                        rd_sel      <= rd_q;
                        stall_clear <= 1'b1;
                        update_rd   <= ~is_store_q;
                        wr_val      <= is_store_q ? 32'h0 : lane_rd_ext;
                    end else if (timeout_hit) begin
                        // Abandoned access never writes a register.
                        rd_sel      <= rd_q;
                        stall_clear <= 1'b1;
                        bus_error   <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oldland_memory.sv
// Randomized self-checking bench for oldland_memory against an arithmetic lane model.
module tb_oldland_memory;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, store, branch;
    logic [31:0] mem_addr, mem_wr_val, alu_result;
    logic [1:0]  mem_width;
    logic [2:0]  rd_sel_in;
    logic        update_rd_in;
    logic [31:0] d_addr, d_wr_val, d_data, wr_val;
    logic [3:0]  d_bytesel;
    logic        d_wr_en, d_access, d_ack;
    logic [2:0]  rd_sel;
    logic        update_rd, stall_clear, busy, bus_error;

    int checks = 0;
    int errors = 0;

    oldland_memory #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .branch(branch),
        .mem_addr(mem_addr), .mem_wr_val(mem_wr_val), .mem_width(mem_width),
        .alu_result(alu_result), .rd_sel_in(rd_sel_in), .update_rd_in(update_rd_in),
        .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val), .d_wr_en(d_wr_en),
        .d_access(d_access), .d_ack(d_ack), .d_data(d_data),
        .wr_val(wr_val), .rd_sel(rd_sel), .update_rd(update_rd),
        .stall_clear(stall_clear), .busy(busy), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int m_size(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] w, input logic [31:0] a);
        return (a % m_size(w)) != 0;
    endfunction

    function automatic logic [3:0] m_lanes(input logic [1:0] w, input logic [31:0] a);
        int sz = m_size(w);
        int mask = (1 << sz) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] v);
        int sz = m_size(w);
        if (sz == 1) return (v & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic [31:0] a,
                                           input logic [31:0] d);
        int sz = m_size(w);
        logic [31:0] mask;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        return (d >> (8 * (a % 4))) & mask;
    endfunction

    task automatic idle_inputs();
        load = 0; store = 0; branch = 0; update_rd_in = 0;
        mem_addr = 0; mem_wr_val = 0; mem_width = 0; alu_result = 0; rd_sel_in = 0;
        d_ack = 0; d_data = 0;
    endtask

    // One load/store instruction from acceptance through the cycle after COMPLETE.
    task automatic run_mem(input string nm, input bit ld, input bit st, input bit br,
                           input logic [31:0] addr, input logic [1:0] w,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata, input logic [2:0] rd);
        bit eff_store = st;
        bit mis = m_mis(w, addr);
        bit timed_out = 0;
        int k = 0;
        int high = 0;
        bit done = 0;
        @(posedge clk); #1;
        load = ld; store = st; branch = br; mem_addr = addr; mem_width = w;
        mem_wr_val = wdata; rd_sel_in = rd; update_rd_in = 1; alu_result = $urandom;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || d_access !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b d_access=%b want busy=1 d_access=0", nm, busy, d_access);
        end
        @(posedge clk); #1;
        load = 0; store = 0; branch = 0; update_rd_in = 0;
        if (!mis) begin
            while (!done && k < 64) begin
                d_ack = (k == ack_at);
                d_data = (k == ack_at) ? rdata : $urandom;
                @(negedge clk);
                if (d_access === 1'b1) high++;
                checks++;
                if (d_access !== 1'b1 || d_addr !== (addr & 32'hFFFF_FFFC) ||
                    d_bytesel !== m_lanes(w, addr) || d_wr_en !== eff_store ||
                    (eff_store && d_wr_val !== m_wdata(w, wdata)) || stall_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus k=%0d: acc=%b addr=%h sel=%b wv=%h we=%b sc=%b want acc=1 addr=%h sel=%b wv=%h we=%b sc=0",
                             nm, k, d_access, d_addr, d_bytesel, d_wr_val, d_wr_en, stall_clear,
                             addr & 32'hFFFF_FFFC, m_lanes(w, addr), m_wdata(w, wdata), eff_store);
                end
                @(posedge clk); #1;
                d_ack = 0; d_data = 0;
                if (k == ack_at) done = 1;
                else if (k == TO - 1) begin done = 1; timed_out = 1; end
                k++;
            end
            checks++;
            if (high !== (timed_out ? TO : ack_at + 1)) begin
                errors++;
                $display("FAIL %s d_access cycles: got %0d want %0d", nm, high, timed_out ? TO : ack_at + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (d_access !== 1'b0 || stall_clear !== 1'b1 || bus_error !== (mis || timed_out)) begin
            errors++;
            $display("FAIL %s complete: acc=%b sc=%b err=%b want acc=0 sc=1 err=%b",
                     nm, d_access, stall_clear, bus_error, mis || timed_out);
        end
        checks++;
        if (mis) begin
            if (update_rd !== 1'b0) begin
                errors++;
                $display("FAIL %s misalign update_rd=%b want 0", nm, update_rd);
            end
        end else if (timed_out) begin
            if (wr_val !== 32'h0) begin
                errors++;
                $display("FAIL %s timeout wr_val=%h want 0", nm, wr_val);
            end
        end else if (eff_store) begin
            if (update_rd !== 1'b0) begin
                errors++;
                $display("FAIL %s store update_rd=%b want 0", nm, update_rd);
            end
        end else begin
            if (update_rd !== 1'b1 || wr_val !== m_load(w, addr, rdata) || rd_sel !== rd) begin
                errors++;
                $display("FAIL %s load result: upd=%b wr_val=%h rd=%0d want upd=1 wr_val=%h rd=%0d",
                         nm, update_rd, wr_val, rd_sel, m_load(w, addr, rdata), rd);
            end
        end
        @(negedge clk);
        checks++;
        if (stall_clear !== 1'b0 || bus_error !== 1'b0 || d_access !== 1'b0) begin
            errors++;
            $display("FAIL %s after: sc=%b err=%b acc=%b want 0 0 0", nm, stall_clear, bus_error, d_access);
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({d_access, d_wr_en, update_rd, stall_clear, busy, bus_error} !== 6'b0 ||
            d_addr !== 0 || d_bytesel !== 0 || d_wr_val !== 0 || wr_val !== 0 || rd_sel !== 0) begin
            errors++;
            $display("FAIL reset outputs: acc=%b we=%b upd=%b sc=%b busy=%b err=%b addr=%h wr_val=%h want all 0",
                     d_access, d_wr_en, update_rd, stall_clear, busy, bus_error, d_addr, wr_val);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_spec_cases();
        run_mem("word_load",   1, 0, 0, 32'h100, 2'd2, 32'h0,       3,  32'hDEADBEEF, 3'd1);
        run_mem("byte_store",  0, 1, 0, 32'h203, 2'd0, 32'h0000_00A5, 1, 32'h0,       3'd2);
        run_mem("half_load",   1, 0, 0, 32'h102, 2'd1, 32'h0,       0,  32'h1234ABCD, 3'd3);
        run_mem("byte_load",   1, 0, 0, 32'h101, 2'd0, 32'h0,       2,  32'h1234ABCD, 3'd4);
        run_mem("misalign",    1, 0, 0, 32'h102, 2'd2, 32'h0,       0,  32'h0,        3'd5);
        run_mem("timeout",     1, 0, 0, 32'h200, 2'd2, 32'h0,       -1, 32'h0,        3'd6);
        run_mem("ld_st_both",  1, 1, 0, 32'h304, 2'd2, 32'hCAFEF00D, 0, 32'h11111111, 3'd7);
        run_mem("ld_branch",   1, 0, 1, 32'h408, 2'd1, 32'h0,       1,  32'h89AB4567, 3'd2);
    endtask

    task automatic test_branch();
        @(posedge clk); #1;
        branch = 1; update_rd_in = 1; alu_result = 32'h40; rd_sel_in = 3'd5;
        @(negedge clk);
        checks++;
        if (stall_clear !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL branch issue: sc=%b busy=%b want 0 0", stall_clear, busy);
        end
        @(posedge clk); #1;
        branch = 0; update_rd_in = 0; alu_result = 32'h0;
        @(negedge clk);
        checks++;
        if (stall_clear !== 1'b1 || wr_val !== 32'h40 || update_rd !== 1'b1 || rd_sel !== 3'd5) begin
            errors++;
            $display("FAIL branch result: sc=%b wr_val=%h upd=%b rd=%0d want 1 00000040 1 5",
                     stall_clear, wr_val, update_rd, rd_sel);
        end
        @(negedge clk);
        checks++;
        if (stall_clear !== 1'b0) begin
            errors++;
            $display("FAIL branch pulse width: sc=%b want 0", stall_clear);
        end
    endtask

    // Back-to-back ALU passthrough with stray d_ack pulses that must be ignored.
    task automatic test_back_to_back();
        logic [31:0] pv;
        logic [2:0]  pr;
        logic        pu;
        @(posedge clk); #1;
        pv = $urandom; pr = 3'($urandom); pu = 1'($urandom);
        alu_result = pv; rd_sel_in = pr; update_rd_in = pu; d_ack = 1'($urandom);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            alu_result = $urandom; rd_sel_in = 3'($urandom); update_rd_in = 1'($urandom);
            d_ack = 1'($urandom); d_data = $urandom;
            @(negedge clk);
            checks++;
            if (wr_val !== pv || rd_sel !== pr || update_rd !== pu || stall_clear !== 1'b0 ||
                d_access !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL alu_pass %0d: wr_val=%h rd=%0d upd=%b sc=%b acc=%b busy=%b want %h %0d %b 0 0 0",
                         i, wr_val, rd_sel, update_rd, stall_clear, d_access, busy, pv, pr, pu);
            end
            pv = alu_result; pr = rd_sel_in; pu = update_rd_in;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        load = 1; mem_addr = 32'h500; mem_width = 2'd2; rd_sel_in = 3'd3;
        @(posedge clk); #1;
        load = 0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (d_access !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: d_access=%b want 1", d_access);
        end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({d_access, d_wr_en, update_rd, stall_clear, busy, bus_error} !== 6'b0 ||
                d_addr !== 0 || wr_val !== 0) begin
                errors++;
                $display("FAIL rst_mid %0d: acc=%b upd=%b sc=%b busy=%b err=%b addr=%h want all 0",
                         i, d_access, update_rd, stall_clear, busy, bus_error, d_addr);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int op = $urandom_range(0, 2);
            int ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            run_mem("random", op != 1, op != 0, 1'($urandom), $urandom, 2'($urandom_range(0, 3)),
                    $urandom, ack, $urandom, 3'($urandom));
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_spec_cases();
        test_branch();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oldland_memory.md
Name: oldland_memory

Overview:
- Memory stage of the oldland pipeline; the consuming end of the fetch stall handshake.
- Executes load/store transactions on the data bus and writes results toward writeback.
- Issues the one-cycle stall_clear pulse that releases fetch once a stalling instruction (load, store or branch) resolves here.
- Sits between execute and writeback.

Parameters:
- BUS_TIMEOUT, 16, cycles to wait for d_ack before abandoning the access and flagging bus_error.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- load  in  1  execute: instruction is a load
- store  in  1  execute: instruction is a store
- branch  in  1  execute: instruction is a stalling non-memory op (branch/call/ret)
- mem_addr  in  32  effective address from ALU
- mem_wr_val  in  32  store data (low bits significant for byte/half)
- mem_width  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- alu_result  in  32  non-load result passthrough
- rd_sel_in  in  3  destination register
- update_rd_in  in  1  instruction writes rd
- d_addr  out  32  data bus address, word aligned (low 2 bits zero)
- d_bytesel  out  4  byte lane enables
- d_wr_val  out  32  lane-replicated store data
- d_wr_en  out  1  write strobe qualifier
- d_access  out  1  bus request, held until d_ack or timeout
- d_ack  in  1  bus completion, single cycle
- d_data  in  32  read data, valid with d_ack
- wr_val  out  32  writeback value
- rd_sel  out  3  writeback destination
- update_rd  out  1  writeback enable
- stall_clear  out  1  one-cycle pulse to fetch
- busy  out  1  stage occupied; execute must hold its inputs
- bus_error  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-access drops d_access next edge and emits no stall_clear.
- FSM states:
  - IDLE: accept inputs each cycle.
  - ACCESS: drive the bus and wait for ack.
  - COMPLETE: one-cycle result/writeback slot.
- IDLE, load|store, aligned -> ACCESS. Registered bus outputs assert the following cycle; busy=1 combinationally from the same cycle.
- IDLE, branch (no load/store) -> stay IDLE. Next cycle: stall_clear=1; update_rd/wr_val=alu_result per update_rd_in.
- IDLE, plain ALU op -> registered passthrough: wr_val/rd_sel/update_rd one cycle later; no stall_clear.
- ACCESS:
  - d_ack=1 -> COMPLETE; latch d_data.
  - Otherwise increment counter; counter==BUS_TIMEOUT-1 without ack -> COMPLETE with bus_error=1, load result 0.
  - d_access must drop in the cycle after ack/timeout.
- COMPLETE:
  - Load: update_rd=1, wr_val=extracted data.
  - Store: update_rd=0.
  - stall_clear=1 in this cycle; -> IDLE.
  - Exactly one stall_clear per stalling instruction.
- Alignment (byte/half/word):
  - byte: always legal.
  - half: legal when mem_addr[0]=0.
  - word: legal when mem_addr[1:0]=0.
  - Misaligned -> no bus access. Go straight to COMPLETE next cycle: bus_error=1, stall_clear=1, update_rd=0.
- Lanes (little-endian):
  - byte: bytesel=1<<addr[1:0]; wr_val replicated x4.
  - half: bytesel=addr[1]?4'b1100:4'b0011; wr_val replicated x2.
  - word: bytesel=4'b1111.
  - Loads zero-extend the selected lanes.
- Simultaneous load and store asserted: store wins. load|store with branch: memory path wins; single stall_clear.
- d_ack while IDLE is ignored.
- Inputs arriving while busy=1 are ignored; execute holds them (guaranteed since fetch is stalled).

Decomposition:
- Shared oldland_defines: width encodings (MEM_BYTE/HALF/WORD), FSM state localparams, INSTR_NOP.
- Sub-module oldland_mem_lanes: combinational bytesel/store replication/load extraction/misalign detect, reused by a future cache.

Test Plan:
- Word load, addr 0x100, d_ack 3 cycles after d_access, d_data 0xDEADBEEF:
  - d_addr=0x100, bytesel=1111.
  - COMPLETE: wr_val=0xDEADBEEF, update_rd=1, stall_clear for exactly 1 cycle.
- Byte store 0x000000A5 to 0x203:
  - d_addr=0x200, bytesel=1000, d_wr_val=0xA5A5A5A5, d_wr_en=1.
  - After ack: stall_clear pulse, update_rd=0.
- Half load 0x102, d_data 0x1234ABCD -> wr_val=0x00001234. Byte load 0x101 -> wr_val=0x000000AB.
- Word load at 0x102 -> d_access never asserts; next cycle bus_error=1, stall_clear=1, update_rd=0.
- No d_ack, BUS_TIMEOUT=16 -> d_access drops after 16 cycles; bus_error and stall_clear pulse together; wr_val=0.
- Branch with update_rd_in=1, alu_result=0x40 -> next cycle stall_clear=1, wr_val=0x40. Separately: rst asserted while in ACCESS -> next cycle all outputs 0, no stall_clear.
